// File: rtl/pipo_pkg.sv
// pipo_pkg: shared defaults and data word type for the pipo register chain
package pipo_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 1;
  typedef logic [DEFAULT_WIDTH-1:0] word_t;
endpackage

// File: rtl/pipo_stage.sv
// pipo_stage: one load-enabled register; ports clk, rst (sync active-low), load, d in, q out
module pipo_stage
  import pipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (!rst) q <= RESET_VALUE;
    else if (load) q <= d;
endmodule

// File: rtl/pipo.sv
// pipo: DEPTH-stage parallel-in/parallel-out register sharing one load; ports clk, rst (sync active-low), load, pi in, po out
module pipo
  import pipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pi,
  output logic [WIDTH-1:0] po
);
  logic [WIDTH-1:0] q [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] d;
    if (g == 0) begin : g_first
      assign d = pi;
    end else begin : g_rest
      assign d = q[g-1];
    end
    pipo_stage #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
      .clk(clk), .rst(rst), .load(load), .d(d), .q(q[g])
    );
  end
  assign po = q[DEPTH-1];
endmodule

// File: tb/tb_pipo.sv
// tb_pipo: randomized and directed checks of pipo at DEPTH=1 and DEPTH=3 against a queue model
module tb_pipo;
  logic clk = 1'b0;
  logic rst, load;
  logic [3:0] pi, po1, po3;
  logic [3:0] m1;
  logic [3:0] m3[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipo #(.WIDTH(4), .DEPTH(1)) dut1 (.clk(clk), .rst(rst), .load(load), .pi(pi), .po(po1));
  pipo #(.WIDTH(4), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .load(load), .pi(pi), .po(po3));

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [3:0] p);
    rst = r;
    load = l;
    pi = p;
    @(posedge clk);
    if (r === 1'b0) begin
      m1 = 4'h0;
      m3 = '{4'h0, 4'h0, 4'h0};
    end else if (l) begin
      m1 = p;
      m3.push_front(p);
      void'(m3.pop_back());
    end
    @(negedge clk);
    check("model_d1", po1, m1);
    check("model_d3", po3, m3[2]);
  endtask

  initial begin
    m1 = 4'h0;
    m3 = '{4'h0, 4'h0, 4'h0};
    @(negedge clk);
    step(1'b0, 1'bx, 4'bxxxx);
    check("reset_x_d1", po1, 4'b0000);
    check("reset_x_d3", po3, 4'b0000);
    step(1'b1, 1'b1, 4'b1101);
    check("load_1101", po1, 4'b1101);
    step(1'b1, 1'b1, 4'b1101);
    check("reload_1101", po1, 4'b1101);
    step(1'b1, 1'b0, 4'b1010);
    check("hold_a", po1, 4'b1101);
    step(1'b1, 1'b0, 4'b0110);
    check("hold_b", po1, 4'b1101);
    step(1'b1, 1'b0, 4'b1110);
    check("hold_c", po1, 4'b1101);
    step(1'b0, 1'b1, 4'b1111);
    check("reset_wins", po1, 4'b0000);
    step(1'b1, 1'b1, 4'b0110);
    check("load_after_rst", po1, 4'b0110);
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'h1);
    check("d3_lat1", po3, 4'h0);
    step(1'b1, 1'b1, 4'h2);
    check("d3_lat2", po3, 4'h0);
    step(1'b1, 1'b1, 4'h3);
    check("d3_first", po3, 4'h1);
    step(1'b1, 1'b0, 4'h9);
    step(1'b1, 1'b0, 4'h7);
    check("d3_hold", po3, 4'h1);
    step(1'b1, 1'b1, 4'h4);
    check("d3_advance", po3, 4'h2);
    check("d1_advance", po1, 4'h4);
    for (int i = 0; i < 1000; i++)
      step(($urandom_range(0, 19) != 0), 1'($urandom), 4'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
